// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring_checker monitor.
package ring_pkg;

    localparam int unsigned ROT_W     = 8;
    localparam int unsigned ROR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Rotate the low w bits of v right by one; bits above w must be zero.
    function automatic logic [ROR_MAX_W-1:0] ror1(input logic [ROR_MAX_W-1:0] v,
                                                  input int unsigned         w);
        return (v >> 1) | (ROR_MAX_W'(v[0]) << (w - 1));
    endfunction

    function automatic int unsigned ctr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]           vec_i,
    output logic [$clog2(WIDTH+1)-1:0] cnt_o
);

    localparam int unsigned OUT_W = $clog2(WIDTH + 1);

    always_comb begin
        cnt_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_o = cnt_o + OUT_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/ring_checker.sv
// Monitors a circular shift register: predicts each word from the previous
// prediction, counts mismatches and completed rotations, ends with done.
module ring_checker
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       s,
    input  logic [WIDTH-1:0]           result,
    input  logic                       start,
    input  logic [ROT_W-1:0]           n_rot,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [CNT_W-1:0]           err_cnt,
    output logic [ROT_W-1:0]           rot_cnt,
    output logic [$clog2(WIDTH+1)-1:0] ones
);

    localparam int unsigned STEP_W = ctr_w(WIDTH);
    localparam int unsigned ONES_W = $clog2(WIDTH + 1);

    function automatic logic [WIDTH-1:0] ror(input logic [WIDTH-1:0] v);
        return WIDTH'(ror1(ROR_MAX_W'(v), WIDTH));
    endfunction

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [ROT_W-1:0]    rot_q, rot_d;
    logic [ROT_W-1:0]    nrot_q, nrot_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    errcnt_q, errcnt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ONES_W-1:0]   pop_c;
    logic                last_step_c;
    logic [ROT_W-1:0]    rot_next_c;

    popcount #(.WIDTH(WIDTH)) u_popcount (
        .vec_i (result),
        .cnt_o (pop_c)
    );

    assign last_step_c = (step_q == STEP_W'(WIDTH - 1));
    assign rot_next_c  = rot_q + ROT_W'(1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (n_rot == '0) ? DONE : TRACK;
            TRACK:   if (last_step_c && (rot_next_c == nrot_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags decoded from the next state so they register in step with it.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Prediction chains from exp_q only, so a single fault is never self-healed.
    always_comb begin
        exp_d    = exp_q;
        step_d   = step_q;
        rot_d    = rot_q;
        nrot_d   = nrot_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        ones_d   = ones_q;
        if (state_q == IDLE && start) begin
            exp_d    = s ? ror(result) : '0;
            step_d   = '0;
            rot_d    = '0;
            nrot_d   = n_rot;
            err_d    = 1'b0;
            errcnt_d = '0;
            ones_d   = pop_c;
        end else if (state_q == TRACK) begin
            if (result != exp_q) begin
                err_d = 1'b1;
                if (errcnt_q != {CNT_W{1'b1}}) errcnt_d = errcnt_q + CNT_W'(1);
            end
            exp_d = s ? ror(exp_q) : '0;
            if (last_step_c) begin
                step_d = '0;
                rot_d  = rot_next_c;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp_q    <= '0;
            step_q   <= '0;
            rot_q    <= '0;
            nrot_q   <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
            ones_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            step_q   <= step_d;
            rot_q    <= rot_d;
            nrot_q   <= nrot_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            ones_q   <= ones_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign err_cnt = errcnt_q;
    assign rot_cnt = rot_q;
    assign ones    = ones_q;

endmodule
